// File: rtl/i2c_reg_master.sv
// i2c_reg_master: PIO-driven I2C master for single-byte register writes
// and burst register reads into a small buffer, with NACK reporting.
module i2c_reg_master #(
    parameter int CLK_DIV = 125,
    parameter int MAX_LEN = 6,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] rd_sel,
    output logic [7:0]       rd_data,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             sda_in
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [1:0]       qtr;
    logic [3:0]       bitn;
    logic             start_s;
    logic             start_q;
    logic             rw_l;
    logic [6:0]       dev_l;
    logic [7:0]       reg_l;
    logic [7:0]       wd_l;
    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] idx;
    logic [6:0]       shreg;
    logic             samp;
    logic [7:0]       buffer [MAX_LEN];

    logic       req;
    logic       tick;
    logic       last_byte;
    logic       tx_bit;
    logic       scl_lo;
    logic [7:0] tx_byte;
    logic       scl_nx;
    logic       sda_nx;

    assign req       = start_s & ~start_q;
    assign tick      = (div == DIV_W'(CLK_DIV - 1));
    assign last_byte = (idx == eff_len - LEN_W'(1));
    assign scl_lo    = (qtr == 2'd0) || (qtr == 2'd3);
    assign tx_bit    = tx_byte[3'd7 - bitn[2:0]];

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ADDR_W:  tx_byte = {dev_l, 1'b0};
            REG:     tx_byte = reg_l;
            WDATA:   tx_byte = wd_l;
            ADDR_R:  tx_byte = {dev_l, 1'b1};
            default: tx_byte = 8'h00;
        endcase
    end

    // Line drive for the current quarter; registered one cycle later.
    always_comb begin
        scl_nx = 1'b0;
        sda_nx = 1'b0;
        case (state)
            START, RSTART: begin
                scl_nx = scl_lo;
                sda_nx = qtr[1];
            end
            STOP: begin
                scl_nx = (qtr == 2'd0);
                sda_nx = ~qtr[1];
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                scl_nx = scl_lo;
                sda_nx = (bitn != 4'd8) & ~tx_bit;
            end
            RDATA: begin
                scl_nx = scl_lo;
                sda_nx = (bitn == 4'd8) & ~last_byte;
            end
            default: begin
                scl_nx = 1'b0;
                sda_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div     <= '0;
            qtr     <= 2'd0;
            bitn    <= 4'd0;
            start_s <= 1'b0;
            start_q <= 1'b0;
            rw_l    <= 1'b0;
            dev_l   <= 7'h00;
            reg_l   <= 8'h00;
            wd_l    <= 8'h00;
            eff_len <= LEN_W'(1);
            idx     <= '0;
            shreg   <= 7'h00;
            samp    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            rd_data <= 8'h00;
            for (int i = 0; i < MAX_LEN; i++) buffer[i] <= 8'h00;
        end else begin
            start_s <= start;
            start_q <= start_s;
            scl_oe  <= scl_nx;
            sda_oe  <= sda_nx;
            rd_data <= (int'(rd_sel) < MAX_LEN) ? buffer[rd_sel] : 8'h00;
            if (state == IDLE) begin
                div <= '0;
                if (req) begin
                    rw_l  <= rw;
                    dev_l <= dev_addr;
                    reg_l <= reg_addr;
                    wd_l  <= wr_data;
                    if (len == '0)
                        eff_len <= LEN_W'(1);
                    else if (len > LEN_W'(MAX_LEN))
                        eff_len <= LEN_W'(MAX_LEN);
                    else
                        eff_len <= len;
                    idx   <= '0;
                    qtr   <= 2'd0;
                    bitn  <= 4'd0;
                    done  <= 1'b0;
                    nack  <= 1'b0;
                    busy  <= 1'b1;
                    state <= START;
                end
            end else begin
                div <= tick ? '0 : div + DIV_W'(1);
                if (tick) begin
                    qtr <= qtr + 2'd1;
                    if (qtr == 2'd2) samp <= sda_in;
                    if (qtr == 2'd3) begin
                        case (state)
                            START: begin
                                state <= ADDR_W;
                                bitn  <= 4'd0;
                            end
                            RSTART: begin
                                state <= ADDR_R;
                                bitn  <= 4'd0;
                            end
                            STOP: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                            RDATA: begin
                                if (bitn != 4'd8) begin
                                    bitn  <= bitn + 4'd1;
                                    shreg <= {shreg[5:0], samp};
                                    if (bitn == 4'd7)
                                        buffer[idx] <= {shreg, samp};
                                end else if (last_byte) begin
                                    state <= STOP;
                                end else begin
                                    idx  <= idx + LEN_W'(1);
                                    bitn <= 4'd0;
                                end
                            end
                            default: begin
                                if (bitn != 4'd8) begin
                                    bitn <= bitn + 4'd1;
                                end else if (samp) begin
                                    nack  <= 1'b1;
                                    state <= STOP;
                                end else begin
                                    bitn <= 4'd0;
                                    case (state)
                                        ADDR_W:  state <= REG;
                                        REG:     state <= rw_l ? RSTART : WDATA;
                                        ADDR_R:  state <= RDATA;
                                        default: state <= STOP;
                                    endcase
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule
